// File: rtl/eth_miim_frame_seq_pkg.sv
// Shared definitions for the MII management frame sequencer: slot map, opcodes,
// FSM states, latched command record and the per-slot serial bit lookup.
package eth_miim_defs;

  localparam int unsigned PRE_END  = 31;
  localparam int unsigned ST       = 32;
  localparam int unsigned OP       = 34;
  localparam int unsigned PHYAD    = 36;
  localparam int unsigned REGAD    = 41;
  localparam int unsigned TA       = 46;
  localparam int unsigned DATA     = 48;
  localparam int unsigned DATA_END = 63;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        write;
    logic        nopre;
    logic [4:0]  fiad;
    logic [4:0]  rgad;
    logic [15:0] data;
  } cmd_t;

  // Serial bit for a given slot; with nopre, slot 0 carries the first ST bit.
  function automatic logic slot_bit(input logic [6:0] slot, input cmd_t cmd);
    int unsigned s;
    logic [1:0]  op;
    logic        b;
    s  = 32'(slot);
    op = cmd.write ? OP_WRITE : OP_READ;
    b  = 1'b0;
    if (s <= PRE_END)       b = !(cmd.nopre && (s == 0));
    else if (s < OP)        b = (s == ST + 1);
    else if (s < PHYAD)     b = (s == OP) ? op[1] : op[0];
    else if (s < REGAD)     b = cmd.fiad[3'(PHYAD + 4 - s)];
    else if (s < TA)        b = cmd.rgad[3'(REGAD + 4 - s)];
    else if (s < DATA)      b = cmd.write && (s == TA);
    else if (s <= DATA_END) b = cmd.write && cmd.data[4'(DATA_END - s)];
    return b;
  endfunction

endpackage

// File: rtl/eth_miim_rdcapture.sv
// Mdi read-data shifter: samples on MdcEn while the slot counter is inside the
// latency-shifted data window.
module eth_miim_rdcapture
  import eth_miim_defs::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc_en,
  input  logic        enable,
  input  logic [6:0]  bit_counter,
  input  logic        mdi,
  output logic [15:0] shift_next
);

  localparam logic [6:0] WIN_LO = 7'(DATA + RD_LAT);
  localparam logic [6:0] WIN_HI = 7'(DATA_END + RD_LAT);

  logic [15:0] shift_q;
  logic        in_window;

  assign in_window = (bit_counter >= WIN_LO) && (bit_counter <= WIN_HI);

  // Exposed pre-register so a sample coincident with the final slot edge
  // still reaches the transfer into Prsd.
  always_comb begin
    shift_next = shift_q;
    if (enable && mdc_en && in_window) shift_next = {shift_q[14:0], mdi};
  end

  always_ff @(posedge clk) begin
    if (reset) shift_q <= '0;
    else       shift_q <= shift_next;
  end

endmodule

// File: rtl/eth_miim_frame_seq.sv
// MDIO frame sequencer: accepts one command, steps bit slots on MdcEn_n,
// serialises the frame and reports completion with WDone/RDone pulses.
module eth_miim_frame_seq
  import eth_miim_defs::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MdcEn,
  input  logic        MdcEn_n,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic        Cmd_Write,
  input  logic        NoPre,
  input  logic [4:0]  Fiad,
  input  logic [4:0]  Rgad,
  input  logic [15:0] CtrlData,
  input  logic        Mdi,
  output logic        InProgress,
  output logic        WriteOp,
  output logic [6:0]  BitCounter,
  output logic        ShiftedBit,
  output logic [15:0] Prsd,
  output logic        WDone,
  output logic        RDone
);

  localparam logic [6:0] LAST = 7'(DATA_END + RD_LAT);

  state_t      state, state_next;
  cmd_t        cmd_q, cmd_next;
  logic [6:0]  bit_counter_next;
  logic [6:0]  slot_next;
  logic        shifted_bit_next;
  logic        in_progress_next;
  logic        wdone_next, rdone_next;
  logic [15:0] prsd_next;
  logic [15:0] capture;

  assign Cmd_Ready = (state == S_IDLE);
  assign WriteOp   = cmd_q.write;

  eth_miim_rdcapture #(
    .RD_LAT(RD_LAT)
  ) u_rdcapture (
    .clk        (Clk),
    .reset      (Reset),
    .mdc_en     (MdcEn),
    .enable     ((state == S_RUN) && !cmd_q.write),
    .bit_counter(BitCounter),
    .mdi        (Mdi),
    .shift_next (capture)
  );

  always_comb begin
    state_next       = state;
    cmd_next         = cmd_q;
    bit_counter_next = BitCounter;
    shifted_bit_next = ShiftedBit;
    in_progress_next = InProgress;
    wdone_next       = 1'b0;
    rdone_next       = 1'b0;
    prsd_next        = Prsd;
    slot_next        = '0;
    case (state)
      S_IDLE: begin
        if (Cmd_Valid) begin
          cmd_next = '{write: Cmd_Write, nopre: NoPre, fiad: Fiad,
                       rgad: Rgad, data: CtrlData};
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (MdcEn_n) begin
          state_next       = S_RUN;
          in_progress_next = 1'b1;
          bit_counter_next = '0;
          shifted_bit_next = slot_bit('0, cmd_q);
        end
      end
      S_RUN: begin
        if (MdcEn_n) begin
          if (BitCounter == LAST) begin
            // Outputs are registered, so idle values are already visible in DONE.
            state_next       = S_DONE;
            in_progress_next = 1'b0;
            bit_counter_next = '0;
            shifted_bit_next = 1'b0;
            wdone_next       = cmd_q.write;
            rdone_next       = !cmd_q.write;
            if (!cmd_q.write) prsd_next = capture;
          end else begin
            slot_next        = (cmd_q.nopre && (BitCounter == '0)) ? 7'(ST + 1)
                                                                  : BitCounter + 7'd1;
            bit_counter_next = slot_next;
            shifted_bit_next = slot_bit(slot_next, cmd_q);
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      BitCounter <= '0;
      ShiftedBit <= 1'b0;
      InProgress <= 1'b0;
      WDone      <= 1'b0;
      RDone      <= 1'b0;
      Prsd       <= '0;
    end else begin
      state      <= state_next;
      cmd_q      <= cmd_next;
      BitCounter <= bit_counter_next;
      ShiftedBit <= shifted_bit_next;
      InProgress <= in_progress_next;
      WDone      <= wdone_next;
      RDone      <= rdone_next;
      Prsd       <= prsd_next;
    end
  end

endmodule

// File: tb/tb_eth_miim_frame_seq.sv
// Scoreboard bench for eth_miim_frame_seq: stimulus pushes per-slot and per-frame
// expectations, a negedge monitor pops and compares as the DUT presents them.
module tb_eth_miim_frame_seq;

  localparam int RD_LAT = 2;
  localparam int LAST   = 63 + RD_LAT;

  logic        Clk = 1'b0;
  logic        Reset, MdcEn, MdcEn_n, Cmd_Valid, Cmd_Write, NoPre, Mdi;
  logic [4:0]  Fiad, Rgad;
  logic [15:0] CtrlData;
  logic        Cmd_Ready, InProgress, WriteOp, ShiftedBit, WDone, RDone;
  logic [6:0]  BitCounter;
  logic [15:0] Prsd;

  eth_miim_frame_seq #(.RD_LAT(RD_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .MdcEn(MdcEn), .MdcEn_n(MdcEn_n),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
    .NoPre(NoPre), .Fiad(Fiad), .Rgad(Rgad), .CtrlData(CtrlData), .Mdi(Mdi),
    .InProgress(InProgress), .WriteOp(WriteOp), .BitCounter(BitCounter),
    .ShiftedBit(ShiftedBit), .Prsd(Prsd), .WDone(WDone), .RDone(RDone)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [6:0] cnt; logic bit_v; logic wr; } slot_exp_t;
  typedef struct { logic wr; logic [15:0] prsd; } done_exp_t;

  slot_exp_t   sb_slot[$];
  done_exp_t   sb_done[$];
  slot_exp_t   es;
  done_exp_t   ed;
  int          checks = 0;
  int          fails  = 0;
  logic        seen_n, seen_rst;
  logic [15:0] prsd_model = 16'h0000;

  always @(posedge Clk) begin
    seen_n   <= MdcEn_n;
    seen_rst <= Reset;
  end

  always @(negedge Clk) begin
    if (seen_rst && !Reset) begin
      checks++;
      if ({InProgress, WriteOp, BitCounter, ShiftedBit, Prsd, WDone, RDone, Cmd_Ready} !==
          {1'b0, 1'b0, 7'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL reset_state: got inprog=%0b wop=%0b cnt=%0d bit=%0b prsd=%h wd=%0b rd=%0b rdy=%0b, expected 0 0 0 0 0000 0 0 1",
                 InProgress, WriteOp, BitCounter, ShiftedBit, Prsd, WDone, RDone, Cmd_Ready);
      end
    end else if (!Reset) begin
      if (seen_n && InProgress) begin
        checks++;
        if (sb_slot.size() == 0) begin
          fails++;
          $display("FAIL extra_slot: got cnt=%0d with no slot expected", BitCounter);
        end else begin
          es = sb_slot.pop_front();
          if ({Cmd_Ready, WriteOp, BitCounter, ShiftedBit} !== {1'b0, es.wr, es.cnt, es.bit_v}) begin
            fails++;
            $display("FAIL slot: got rdy=%0b wop=%0b cnt=%0d bit=%0b, expected rdy=0 wop=%0b cnt=%0d bit=%0b",
                     Cmd_Ready, WriteOp, BitCounter, ShiftedBit, es.wr, es.cnt, es.bit_v);
          end
        end
      end
      if (WDone || RDone) begin
        checks++;
        if (sb_done.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got wd=%0b rd=%0b, expected no pulse", WDone, RDone);
        end else begin
          ed = sb_done.pop_front();
          if ({WDone, RDone, Prsd, InProgress, BitCounter} !== {ed.wr, !ed.wr, ed.prsd, 1'b0, 7'd0}) begin
            fails++;
            $display("FAIL done: got wd=%0b rd=%0b prsd=%h inprog=%0b cnt=%0d, expected wd=%0b rd=%0b prsd=%h inprog=0 cnt=0",
                     WDone, RDone, Prsd, InProgress, BitCounter, ed.wr, !ed.wr, ed.prsd);
          end
        end
        checks++;
        if (sb_slot.size() != 0) begin
          fails++;
          $display("FAIL slot_count: got %0d slots still pending at done, expected 0", sb_slot.size());
        end
      end
    end
  end

  function automatic logic frame_bit(input int slot, input logic wr, input logic np,
                                     input logic [4:0] fa, input logic [4:0] ra,
                                     input logic [15:0] cd);
    logic [63:0] f;
    logic [63:0] t;
    f = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), fa, ra,
         (wr ? 2'b10 : 2'b00), (wr ? cd : 16'h0000)};
    if (slot == 0 && np) return 1'b0;
    if (slot > 63) return 1'b0;
    t = f >> (63 - slot);
    return t[0];
  endfunction

  function automatic logic phy_bit(input int slot, input logic [15:0] w);
    logic [15:0] t;
    if (slot < 48 + RD_LAT || slot > LAST) return 1'b0;
    t = w >> (LAST - slot);
    return t[0];
  endfunction

  task automatic run_frame(input logic wr, input logic np, input logic [4:0] fa,
                           input logic [4:0] ra, input logic [15:0] cd,
                           input logic [15:0] mw, input bit hold, input bit coinc,
                           input int abort_slot);
    int slots[$];
    int n;
    bit got;
    slot_exp_t s;
    done_exp_t d;
    slots.push_back(0);
    for (int i = (np ? 33 : 1); i <= LAST; i++) slots.push_back(i);
    n = slots.size();
    Cmd_Write = wr; NoPre = np; Fiad = fa; Rgad = ra; CtrlData = cd; Cmd_Valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Cmd_Ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL accept_timeout: got Cmd_Ready=0 for 100 cycles, expected 1");
      Cmd_Valid = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++) begin
      s.cnt = 7'(slots[k]); s.bit_v = frame_bit(slots[k], wr, np, fa, ra, cd); s.wr = wr;
      sb_slot.push_back(s);
    end
    d.wr = wr;
    d.prsd = wr ? prsd_model : mw;
    sb_done.push_back(d);
    if (!wr) prsd_model = mw;
    @(posedge Clk); #1;
    if (!hold) Cmd_Valid = 1'b0;
    for (int k = 0; k <= n; k++) begin
      MdcEn_n = 1'b1;
      MdcEn   = coinc;
      if (coinc) Mdi = (k > 0) ? phy_bit(slots[k-1], mw) : 1'b0;
      else       Mdi = (k < n) ? phy_bit(slots[k], mw) : 1'b0;
      @(posedge Clk); #1;
      MdcEn_n = 1'b0; MdcEn = 1'b0;
      if (k == n) break;
      if (abort_slot >= 0 && slots[k] == abort_slot) begin
        @(negedge Clk); #1;
        sb_slot.delete();
        sb_done.delete();
        prsd_model = 16'h0000;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; Cmd_Valid = 1'b0; Mdi = 1'b0;
        return;
      end
      @(posedge Clk); #1;
      MdcEn = !coinc;
      @(posedge Clk); #1;
      MdcEn = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; MdcEn = 1'b0; MdcEn_n = 1'b0; Cmd_Valid = 1'b0; Cmd_Write = 1'b0;
    NoPre = 1'b0; Mdi = 1'b0; Fiad = '0; Rgad = '0; CtrlData = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;

    // write with full preamble
    run_frame(1'b1, 1'b0, 5'h01, 5'h00, 16'hA5C3, 16'h0000, 1'b0, 1'b0, -1);
    // read without preamble
    run_frame(1'b0, 1'b1, 5'h03, 5'h11, 16'h0000, 16'h1234, 1'b0, 1'b0, -1);
    // Cmd_Valid held across a whole frame, then a second back-to-back write
    run_frame(1'b1, 1'b0, 5'h1F, 5'h1E, 16'h0F0F, 16'h0000, 1'b1, 1'b0, -1);
    run_frame(1'b1, 1'b0, 5'h1F, 5'h1E, 16'h0F0F, 16'h0000, 1'b0, 1'b0, -1);
    // reset mid-read at slot 40, then a complete read
    run_frame(1'b0, 1'b0, 5'h0A, 5'h05, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 40);
    run_frame(1'b0, 1'b0, 5'h0A, 5'h05, 16'h0000, 16'h5AA5, 1'b0, 1'b0, -1);
    // MdcEn coincident with MdcEn_n, then a write that must keep Prsd
    run_frame(1'b0, 1'b0, 5'h12, 5'h09, 16'h0000, 16'hC35A, 1'b0, 1'b1, -1);
    run_frame(1'b1, 1'b1, 5'h12, 5'h09, 16'h1357, 16'h0000, 1'b0, 1'b0, -1);

    repeat (10) @(posedge Clk);
    checks++;
    if (sb_slot.size() != 0 || sb_done.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d slots and %0d dones pending, expected 0 and 0",
               sb_slot.size(), sb_done.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/eth_miim_frame_seq.md
Name: eth_miim_frame_seq

Overview:
- Upstream sequencer for the MII management (MDIO) output stage.
- Accepts one read or write command at a time and counts MDIO bit slots on the Mdc-fall enable.
- Drives InProgress, WriteOp, BitCounter and ShiftedBit into the MDIO output-control stage.
- Captures read data from Mdi and reports completion with single-cycle pulses.

Parameters:
- RD_LAT, 2: Mdc periods between a slot being presented on ShiftedBit and the PHY's reply bit being valid on Mdi. Compensates the output-control pipeline. Legal range 0..3.

Ports:
- Clk  in  1  host clock.
- Reset  in  1  reset; synchronous, active-high.
- MdcEn  in  1  one-Clk pulse before Mdc rises; used for Mdi sampling.
- MdcEn_n  in  1  one-Clk pulse before Mdc falls; advances the bit slot.
- Cmd_Valid  in  1  command request.
- Cmd_Ready  out  1  block idle and able to accept a command.
- Cmd_Write  in  1  1 = write frame, 0 = read frame.
- NoPre  in  1  suppress the 32-bit preamble; sampled at accept.
- Fiad  in  5  PHY address.
- Rgad  in  5  register address.
- CtrlData  in  16  write data.
- Mdi  in  1  MDIO input from the pad.
- InProgress  out  1  frame active.
- WriteOp  out  1  latched Cmd_Write.
- BitCounter  out  7  current slot number.
- ShiftedBit  out  1  serial bit for the current slot.
- Prsd  out  16  last read data.
- WDone  out  1  one-Clk pulse at the end of a write frame.
- RDone  out  1  one-Clk pulse at the end of a read frame; Prsd is valid in the same cycle.

Behaviour:
Clock and reset:
- Single clock Clk; synchronous active-high Reset.
- All registers clear on Reset. Outputs after reset: InProgress=0, WriteOp=0, BitCounter=0, ShiftedBit=0, Prsd=0, WDone=0, RDone=0, Cmd_Ready=1 (the cycle after Reset deasserts).

Command accept:
- A command is accepted when Cmd_Valid & Cmd_Ready.
- On accept, latch Cmd_Write, NoPre, Fiad, Rgad and CtrlData.
- Cmd_Ready=0 from the cycle after accept until the DONE cycle.
- Cmd_Valid while busy is ignored; there is no queue.

State machine: IDLE, ARM, RUN, DONE.
- IDLE: Cmd_Ready=1. On accept, go to ARM.
- ARM: wait for MdcEn_n. On that pulse, go to RUN with InProgress=1 and BitCounter=0.
  - InProgress is registered and rises exactly at the MdcEn_n edge.
- RUN: on each MdcEn_n, advance the slot.
  - If NoPre=1 and BitCounter==0, load 33; slot 0 stands in for slot 32.
  - Otherwise BitCounter increments by 1.
  - Final slot is LAST = 63+RD_LAT. On MdcEn_n with BitCounter==LAST, go to DONE.
- DONE: one cycle. InProgress=0, BitCounter=0, pulse WDone or RDone, then return to IDLE.

ShiftedBit per slot (registered, updated together with BitCounter):
- 0..31: preamble, 1 (if NoPre, slot 0 carries 0, the ST first bit).
- 32..33: 0, 1 (ST).
- 34..35: write 0,1; read 1,0 (OP).
- 36..40: Fiad[4:0], MSB first.
- 41..45: Rgad[4:0], MSB first.
- 46..47: write 1,0; read 0 (TA, don't-care to the output stage).
- 48..63: write CtrlData[15:0], MSB first; read 0.
- Above 63: 0.

Read capture:
- On MdcEn, if a read is in RUN and BitCounter is in 48+RD_LAT .. 63+RD_LAT, shift Mdi into an internal 16-bit register, MSB first.
- Transfer to Prsd in the DONE cycle. Prsd holds until the next read completes.
- A write never modifies Prsd.

Boundaries:
- MdcEn and MdcEn_n asserted together: slot advance and sample both occur; the sample uses the pre-advance BitCounter.
- Reset mid-frame: immediate return to IDLE. No WDone/RDone. Prsd is cleared.
- BitCounter never exceeds 66 (RD_LAT=3); there is no wrap.

Decomposition:
- Shared package eth_miim_defs:
  - slot constants: PRE_END=31, ST=32, OP=34, PHYAD=36, REGAD=41, TA=46, DATA=48, DATA_END=63.
  - OP codes: 2'b01 write, 2'b10 read.
  - state encoding.
- One natural sub-module: eth_miim_rdcapture (16-bit Mdi shift and capture window compare).

Test Plan:
1. Write, Fiad=5'h01, Rgad=5'h00, CtrlData=16'hA5C3, NoPre=0, MdcEn_n every 4 Clk -> ShiftedBit slots 0..31 all 1; slots 32..47 give 0101 00001 00000 10; slots 48..63 give A5C3 MSB first; one WDone pulse; InProgress high for 66 MdcEn_n periods with RD_LAT=2.
2. Read with NoPre=1, Mdi driven with 16'h1234 aligned to slots 50..65 -> BitCounter sequence 0,33,34,...,65; RDone pulse; Prsd=16'h1234 in the RDone cycle.
3. Cmd_Valid held high through a frame -> exactly one accept per frame; second command starts only after DONE; Cmd_Ready low throughout RUN.
4. Reset asserted at BitCounter=40 during a read -> next cycle InProgress=0, BitCounter=0, Prsd=0, no RDone; a new command runs a full frame.
5. MdcEn coincident with MdcEn_n at the first capture slot -> the Mdi bit lands in Prsd[15]; a following write leaves Prsd unchanged.
